sine_dds_multi: RTL and testbench

// - UART-controlled sine generator for NUM_CH channels. Each channel has its own mode and frequency tuning word (FTW).
// - Sits between uart_rx (rx_valid/rx_byte) and the DAC pins.
// - Internal mode: phase-accumulator DDS.
// - External mode: steps one table entry per rising edge of an external pulse input.
// - Fully synchronous on clk; no derived clocks.

---
 rtl/sine_pkg.sv | 29 ++
 rtl/sine_quarter_lut.sv | 49 ++++
 rtl/sine_dds_multi.sv | 160 ++++++++++++++++
 tb/tb_sine_dds_multi.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sine_pkg.sv
// Shared constants for the multi-channel sine DDS: opcodes, channel modes,
// parser states and table sizing helpers.
package sine_pkg;

  localparam logic [3:0] OP_SET_MODE = 4'h1;
  localparam logic [3:0] OP_SET_FTW  = 4'h2;
  localparam logic [3:0] OP_SYNC     = 4'h3;

  localparam logic [1:0] MODE_OFF = 2'd0;
  localparam logic [1:0] MODE_EXT = 2'd1;
  localparam logic [1:0] MODE_INT = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_EXEC} pstate_e;

  localparam real PI = 3.14159265358979;

  function automatic int midscale(input int out_w);
    return 2 ** (out_w - 1);
  endfunction

  // Quarter wave includes both endpoints (0 and peak).
  function automatic int qtbl_entries(input int addr_w);
    return 2 ** (addr_w - 2) + 1;
  endfunction

  localparam int MIDSCALE = 128;
  localparam int QTBL_N   = 257;

endpackage

// File: rtl/sine_quarter_lut.sv
// Quarter-wave sine table with quadrant folding; one registered sample out.
// Table contents are computed at elaboration from ADDR_W/OUT_W.
module sine_quarter_lut
  import sine_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int OUT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [OUT_W-1:0]  sample_o
);

  localparam int QN  = qtbl_entries(ADDR_W) - 1;
  localparam int AMP = midscale(OUT_W) - 1;
  localparam int IW  = ADDR_W - 1;
  localparam logic [OUT_W-1:0] MIDV = OUT_W'(midscale(OUT_W));

  logic [OUT_W-2:0] tbl [0:QN];

  for (genvar k = 0; k <= QN; k++) begin : g_tbl
    localparam int M = $rtoi(real'(AMP) * $sin(PI * real'(k) / real'(2 * QN)) + 0.5);
    assign tbl[k] = (OUT_W-1)'(M);
  end

  logic [1:0]        quad;
  logic [ADDR_W-3:0] q;
  logic [IW-1:0]     idx;
  logic [OUT_W-2:0]  mag;
  logic [OUT_W-1:0]  samp_d, samp_q;

  always_comb begin
    quad = addr_i[ADDR_W-1 -: 2];
    q    = addr_i[ADDR_W-3:0];
    // Odd quadrants walk the quarter table backwards.
    idx  = quad[0] ? IW'(QN) - IW'(q) : IW'(q);
    mag  = tbl[idx];
    samp_d = quad[1] ? MIDV - OUT_W'(mag) : MIDV + OUT_W'(mag);
  end

  always_ff @(posedge clk) begin
    if (rst) samp_q <= MIDV;
    else     samp_q <= samp_d;
  end

  assign sample_o = samp_q;

endmodule

// File: rtl/sine_dds_multi.sv
// UART-byte-controlled multi-channel sine DDS: frame parser, per-channel
// phase accumulators (internal FTW or external pulse stepping) and table lookup.
module sine_dds_multi
  import sine_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int ACC_W       = 24,
  parameter int FTW_W       = 16,
  parameter int ADDR_W      = 10,
  parameter int OUT_W       = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_byte,
  input  logic [NUM_CH-1:0]       ext_pulse,
  output logic [NUM_CH*OUT_W-1:0] sine_wave,
  output logic                    frame_ok,
  output logic                    frame_err
);

  localparam int NB = FTW_W / 8;
  localparam int CW = $clog2(NB + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [OUT_W-1:0] MIDV = OUT_W'(midscale(OUT_W));
  localparam logic [ACC_W-1:0] STEP = ACC_W'(1) << (ACC_W - ADDR_W);

  pstate_e          st_q, st_d;
  logic [3:0]       op_q, op_d, ch_q, ch_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [FTW_W-1:0] dat_q, dat_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             err_q, err_d;
  logic [NUM_CH-1:0] s1_q, s2_q, s3_q, rise;

  always_comb begin
    st_d  = st_q;
    op_d  = op_q;
    ch_d  = ch_q;
    cnt_d = cnt_q;
    dat_d = dat_q;
    tmo_d = tmo_q;
    err_d = 1'b0;
    case (st_q)
      S_IDLE: if (rx_valid) begin
        op_d  = rx_byte[7:4];
        ch_d  = rx_byte[3:0];
        tmo_d = '0;
        case (rx_byte[7:4])
          OP_SET_MODE: begin cnt_d = CW'(1);  st_d = S_DATA; end
          OP_SET_FTW:  begin cnt_d = CW'(NB); st_d = S_DATA; end
          OP_SYNC:     st_d = S_EXEC;
          default:     err_d = 1'b1;
        endcase
      end
      S_DATA: begin
        if (rx_valid) begin
          dat_d = (dat_q << 8) | FTW_W'(rx_byte);
          tmo_d = '0;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) st_d = S_EXEC;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
          err_d = 1'b1;
          st_d  = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q  <= S_IDLE;
      op_q  <= '0;
      ch_q  <= '0;
      cnt_q <= '0;
      dat_q <= '0;
      tmo_q <= '0;
      err_q <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
    end else begin
      st_q  <= st_d;
      op_q  <= op_d;
      ch_q  <= ch_d;
      cnt_q <= cnt_d;
      dat_q <= dat_d;
      tmo_q <= tmo_d;
      err_q <= err_d;
      s1_q  <= ext_pulse;
      s2_q  <= s1_q;
      s3_q  <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  logic in_exec, ch_valid, mode_bad, exec_ok, do_sync, wr_mode, wr_ftw;

  // SYNC ignores the channel field; other ops need a real channel.
  assign in_exec   = (st_q == S_EXEC);
  assign ch_valid  = ({1'b0, ch_q} < 5'(NUM_CH));
  assign mode_bad  = (op_q == OP_SET_MODE) && (dat_q[1:0] == 2'd3);
  assign exec_ok   = in_exec && ((op_q == OP_SYNC) || (ch_valid && !mode_bad));
  assign do_sync   = in_exec && (op_q == OP_SYNC);
  assign wr_mode   = exec_ok && (op_q == OP_SET_MODE);
  assign wr_ftw    = exec_ok && (op_q == OP_SET_FTW);
  assign frame_ok  = exec_ok;
  assign frame_err = err_q | (in_exec & ~exec_ok);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [1:0]       mode_q;
    logic [FTW_W-1:0] ftw_q;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] lut_s, out_q;
    logic             sel;

    assign sel = (ch_q == 4'(c));

    always_comb begin
      acc_d = acc_q;
      if (do_sync) acc_d = '0;
      else begin
        case (mode_q)
          MODE_INT: acc_d = acc_q + ACC_W'(ftw_q);
          MODE_EXT: if (rise[c]) acc_d = acc_q + STEP;
          default:  acc_d = acc_q;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        mode_q <= MODE_OFF;
        ftw_q  <= '0;
        acc_q  <= '0;
        out_q  <= MIDV;
      end else begin
        if (wr_mode && sel) mode_q <= dat_q[1:0];
        if (wr_ftw && sel)  ftw_q  <= dat_q;
        acc_q <= acc_d;
        out_q <= (mode_q == MODE_OFF) ? MIDV : lut_s;
      end
    end

    sine_quarter_lut #(.ADDR_W(ADDR_W), .OUT_W(OUT_W)) u_lut (
      .clk      (clk),
      .rst      (rst),
      .addr_i   (acc_q[ACC_W-1 -: ADDR_W]),
      .sample_o (lut_s)
    );

    assign sine_wave[c*OUT_W +: OUT_W] = out_q;
  end

endmodule

// File: tb/tb_sine_dds_multi.sv
// Scenario bench for sine_dds_multi: UART frames, INT/EXT stepping, errors,
// timeout, SYNC alignment and mid-frame reset against an arithmetic sine model.
module tb_sine_dds_multi;

  localparam int TMO = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic [1:0]  ext_pulse = 2'b00;
  logic [15:0] sine_wave;
  logic        frame_ok, frame_err;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int x_sync;

  sine_dds_multi #(.NUM_CH(2), .ACC_W(24), .FTW_W(16), .ADDR_W(10), .OUT_W(8),
                   .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .ext_pulse(ext_pulse), .sine_wave(sine_wave),
    .frame_ok(frame_ok), .frame_err(frame_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Ideal sine of a 24-bit phase, top 10 bits as address, rounded half away from zero.
  function automatic logic [7:0] ref_sample(input longint acc);
    int a, r;
    real m;
    a = int'((acc & 64'hFFFFFF) >> 14);
    m = 127.0 * $sin(2.0 * 3.14159265358979 * real'(a) / 1024.0);
    if (m >= 0.0) r = $rtoi(m + 0.5);
    else          r = -$rtoi(-m + 0.5);
    return 8'(128 + r);
  endfunction

  function automatic longint macc(input longint ba, input int bc, input longint bf, input int c);
    return (ba + longint'(c - bc) * bf) & 64'hFFFFFF;
  endfunction

  task automatic send_byte(input logic [7:0] b, output logic ok, output logic err, output int at);
    rx_byte = b;
    rx_valid = 1'b1;
    @(negedge clk);
    ok = frame_ok;
    err = frame_err;
    at = cyc;
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (sine_wave !== 16'h8080) begin n_err++; $display("FAIL reset_out: got %h expected 8080", sine_wave); end
    rst = 1'b0;
    repeat (50) begin
      @(negedge clk);
      n_vec++;
      if (sine_wave !== 16'h8080 || frame_ok !== 1'b0 || frame_err !== 1'b0) begin
        n_err++; $display("FAIL reset_idle: got %h ok %b err %b expected 8080 0 0", sine_wave, frame_ok, frame_err);
      end
    end
  endtask

  task automatic test_int;
    logic ok, err; int at, e0;
    send_byte(8'h20, ok, err, at);
    send_byte(8'h40, ok, err, at);
    send_byte(8'h00, ok, err, at);
    n_vec++;
    if (ok !== 1'b1 || err !== 1'b0) begin n_err++; $display("FAIL ftw_frame: got ok %b err %b expected 1 0", ok, err); end
    send_byte(8'h10, ok, err, at);
    send_byte(8'h02, ok, err, e0);
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL int_mode_frame: got ok %b expected 1", ok); end
    for (int k = 0; k < 1100; k++) begin
      wait_cyc(e0 + 3 + k);
      n_vec++;
      if (sine_wave[7:0] !== ref_sample(longint'(k) * 64'h4000) || sine_wave[15:8] !== 8'h80) begin
        n_err++; $display("FAIL int_ch0 k=%0d: got %h expected %h80", k, sine_wave, ref_sample(longint'(k) * 64'h4000));
      end
    end
  endtask

  task automatic test_ext;
    logic ok, err; int at;
    send_byte(8'h11, ok, err, at);
    send_byte(8'h01, ok, err, at);
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL ext_mode_frame: got ok %b expected 1", ok); end
    repeat (5) @(negedge clk);
    n_vec++;
    if (sine_wave[15:8] !== 8'h80) begin n_err++; $display("FAIL ext_start: got %h expected 80", sine_wave[15:8]); end
    for (int i = 1; i <= 5; i++) begin
      ext_pulse[1] = 1'b1;
      repeat (8) @(negedge clk);
      n_vec++;
      if (sine_wave[15:8] !== ref_sample(longint'(i) << 14)) begin
        n_err++; $display("FAIL ext_edge %0d: got %h expected %h", i, sine_wave[15:8], ref_sample(longint'(i) << 14));
      end
      repeat (2) @(negedge clk);
      ext_pulse[1] = 1'b0;
      repeat ($urandom_range(10, 20)) @(negedge clk);
      n_vec++;
      if (sine_wave[15:8] !== ref_sample(longint'(i) << 14)) begin
        n_err++; $display("FAIL ext_hold %0d: got %h expected %h", i, sine_wave[15:8], ref_sample(longint'(i) << 14));
      end
    end
  endtask

  task automatic test_bad;
    logic ok, err; int at;
    send_byte(8'h1F, ok, err, at);
    send_byte(8'h02, ok, err, at);
    n_vec++;
    if (ok !== 1'b0 || err !== 1'b1) begin n_err++; $display("FAIL bad_ch: got ok %b err %b expected 0 1", ok, err); end
    send_byte(8'h11, ok, err, at);
    send_byte(8'h03, ok, err, at);
    n_vec++;
    if (ok !== 1'b0 || err !== 1'b1) begin n_err++; $display("FAIL bad_mode3: got ok %b err %b expected 0 1", ok, err); end
    send_byte(8'h70, ok, err, at);
    n_vec++;
    if (ok !== 1'b0 || err !== 1'b1) begin n_err++; $display("FAIL bad_op70: got ok %b err %b expected 0 1", ok, err); end
    send_byte(8'h00, ok, err, at);
    n_vec++;
    if (err !== 1'b1) begin n_err++; $display("FAIL bad_op00: got err %b expected 1", err); end
    n_vec++;
    if (sine_wave[15:8] !== ref_sample(longint'(5) << 14)) begin
      n_err++; $display("FAIL bad_nochange: got %h expected %h", sine_wave[15:8], ref_sample(longint'(5) << 14));
    end
    ext_pulse[1] = 1'b1;
    repeat (8) @(negedge clk);
    ext_pulse[1] = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (sine_wave[15:8] !== ref_sample(longint'(6) << 14)) begin
      n_err++; $display("FAIL bad_still_ext: got %h expected %h", sine_wave[15:8], ref_sample(longint'(6) << 14));
    end
  endtask

  task automatic test_timeout;
    logic ok, err, seen; int at, p0, dt;
    send_byte(8'h20, ok, err, at);
    send_byte(8'h40, ok, err, p0);
    seen = 1'b0; dt = -1;
    while (!seen && cyc < p0 + TMO + 20) begin
      if (frame_err) begin seen = 1'b1; dt = cyc - p0; end
      else @(negedge clk);
    end
    n_vec++;
    if (!seen || dt < TMO - 1 || dt > TMO + 1) begin
      n_err++; $display("FAIL timeout: got seen %b delay %0d expected 1 %0d", seen, dt, TMO);
    end
    @(negedge clk);
    send_byte(8'h10, ok, err, at);
    n_vec++;
    if (ok !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL post_tmo_hdr: got ok %b err %b expected 0 0", ok, err); end
    send_byte(8'h00, ok, err, at);
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL post_tmo_frame: got ok %b expected 1", ok); end
    repeat (4) @(negedge clk);
    repeat (20) begin
      @(negedge clk);
      n_vec++;
      if (sine_wave[7:0] !== 8'h80) begin n_err++; $display("FAIL ch0_off: got %h expected 80", sine_wave[7:0]); end
    end
  endtask

  task automatic test_sync;
    logic ok, err; int at, e0, e1;
    send_byte(8'h30, ok, err, at);
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL sync0: got ok %b expected 1", ok); end
    send_byte(8'h21, ok, err, at);
    send_byte(8'h40, ok, err, at);
    send_byte(8'h00, ok, err, at);
    send_byte(8'h10, ok, err, at);
    send_byte(8'h02, ok, err, e0);
    send_byte(8'h11, ok, err, at);
    send_byte(8'h02, ok, err, e1);
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL both_int: got ok %b expected 1", ok); end
    for (int k = 0; k < 20; k++) begin
      wait_cyc(e1 + 10 + k);
      n_vec++;
      if (sine_wave[7:0] !== ref_sample(longint'(cyc - e0 - 3) * 64'h4000) ||
          sine_wave[15:8] !== ref_sample(longint'(cyc - e1 - 3) * 64'h4000)) begin
        n_err++; $display("FAIL pre_sync k=%0d: got %h expected %h%h", k, sine_wave,
          ref_sample(longint'(cyc - e1 - 3) * 64'h4000), ref_sample(longint'(cyc - e0 - 3) * 64'h4000));
      end
    end
    // Land the SYNC EXEC on the cycle where ch0's accumulator sits at 0xFFC000.
    wait_cyc(e0 + 1023);
    send_byte(8'h30, ok, err, x_sync);
    n_vec++;
    if (ok !== 1'b1 || x_sync != e0 + 1024) begin
      n_err++; $display("FAIL sync_exec: got ok %b cyc %0d expected 1 %0d", ok, x_sync, e0 + 1024);
    end
    for (int k = 0; k < 600; k++) begin
      wait_cyc(x_sync + 3 + k);
      n_vec++;
      if (sine_wave[7:0] !== ref_sample(longint'(k) * 64'h4000) ||
          sine_wave[15:8] !== ref_sample(longint'(k) * 64'h4000)) begin
        n_err++; $display("FAIL post_sync k=%0d: got %h expected both %h", k, sine_wave, ref_sample(longint'(k) * 64'h4000));
      end
    end
  endtask

  task automatic test_random_ftw;
    logic ok, err; int at, f_at, bc, c; longint ba, bf; logic [15:0] nf;
    bc = x_sync + 1; ba = 0; bf = 64'h4000;
    repeat (3) begin
      nf = 16'($urandom_range(1, 65535));
      send_byte(8'h21, ok, err, at);
      send_byte(nf[15:8], ok, err, at);
      send_byte(nf[7:0], ok, err, f_at);
      n_vec++;
      if (ok !== 1'b1) begin n_err++; $display("FAIL rnd_frame %h: got ok %b expected 1", nf, ok); end
      ba = macc(ba, bc, bf, f_at + 1);
      bc = f_at + 1;
      bf = longint'(nf);
      for (int k = 0; k < 300; k++) begin
        wait_cyc(f_at + 3 + k);
        c = cyc;
        n_vec++;
        if (sine_wave[15:8] !== ref_sample(macc(ba, bc, bf, c - 2)) ||
            sine_wave[7:0] !== ref_sample(longint'(c - x_sync - 3) * 64'h4000)) begin
          n_err++; $display("FAIL rnd_ftw %h k=%0d: got %h expected %h%h", nf, k, sine_wave,
            ref_sample(macc(ba, bc, bf, c - 2)), ref_sample(longint'(c - x_sync - 3) * 64'h4000));
        end
      end
    end
  endtask

  task automatic test_rst_midframe;
    logic ok, err; int at;
    send_byte(8'h20, ok, err, at);
    send_byte(8'h12, ok, err, at);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (sine_wave !== 16'h8080 || frame_ok !== 1'b0 || frame_err !== 1'b0) begin
      n_err++; $display("FAIL rst_mid: got %h ok %b err %b expected 8080 0 0", sine_wave, frame_ok, frame_err);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    send_byte(8'h10, ok, err, at);
    n_vec++;
    if (ok !== 1'b0 || err !== 1'b0) begin n_err++; $display("FAIL rst_idle_hdr: got ok %b err %b expected 0 0", ok, err); end
    send_byte(8'h02, ok, err, at);
    n_vec++;
    if (ok !== 1'b1) begin n_err++; $display("FAIL rst_idle_frame: got ok %b expected 1", ok); end
    // FTW was cleared by reset, so INT mode must stay at midscale.
    repeat (40) begin
      @(negedge clk);
      n_vec++;
      if (sine_wave !== 16'h8080) begin n_err++; $display("FAIL rst_ftw0: got %h expected 8080", sine_wave); end
    end
  endtask

  initial begin
    test_reset();
    test_int();
    test_ext();
    test_bad();
    test_timeout();
    test_sync();
    test_random_ftw();
    test_rst_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
